// File: rtl/aes256_key_schedule.sv
// AES-256 key-schedule controller.
// Runs the single-step 256-bit key expansion seven times and keeps all 15
// 128-bit round keys in a register file behind a registered read port with
// one cycle of latency.
// Build option: define KEYSCHED_DEC_ORDER_EN to reverse the read address
// order for the decryption datapath (address 0 returns the last round key).
// Storage, state machine and latency are the same in both builds.
// The ready/busy/done flags are registered from the state, so they follow it
// by one cycle. A start accepted at edge N gives busy for edges N+1..N+7 and
// done after edge N+8.

module aes256_key_schedule #(
   parameter int NUM_RK = 15,
   parameter int ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [255:0]      i_key_in,
   output logic              o_ready,
   output logic              o_busy,
   output logic              o_done,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [127:0]      o_rd_data
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LAST_RC = 4'd7;

   // ---------------------------------------------------------------
   // GF(2^8) helpers and the AES S-box.
   // The S-box is built from the field inverse (x^254) and the affine map,
   // so no 256-entry table is needed.
   // ---------------------------------------------------------------
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         acc = acc ^ (sh & {8{b[i]}});
         sh  = gf_xtime(sh);
      end
      return acc;
   endfunction

   // x^254 = x^(2+4+...+128); the inverse of 0 comes out as 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] res;
      logic [7:0] pw;
      res = 8'h01;
      pw  = a;
      for (int i = 1; i < 8; i++) begin
         pw  = gf_mul(pw, pw);
         res = gf_mul(res, pw);
      end
      return res;
   endfunction

   function automatic logic [7:0] aes_sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {aes_sbox(w[31:24]), aes_sbox(w[23:16]),
              aes_sbox(w[15:8]),  aes_sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rc);
      logic [7:0] r;
      case (rc)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // One AES-256 expansion step: eight words in, the next eight words out.
   function automatic logic [255:0] kexp_step(input logic [255:0] key, input logic [3:0] rc);
      logic [31:0] w [0:7];
      logic [31:0] n [0:7];
      for (int i = 0; i < 8; i++) begin
         w[i] = key[255-32*i -: 32];
      end
      n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon(rc), 24'h000000};
      n[1] = w[1] ^ n[0];
      n[2] = w[2] ^ n[1];
      n[3] = w[3] ^ n[2];
      n[4] = w[4] ^ sub_word(n[3]);
      n[5] = w[5] ^ n[4];
      n[6] = w[6] ^ n[5];
      n[7] = w[7] ^ n[6];
      return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
   endfunction

   // ---------------------------------------------------------------
   // Registers and wires
   // ---------------------------------------------------------------
   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_start_acc;
   logic [255:0]  r_key;
   logic [3:0]    r_cnt;
   logic [127:0]  r_rk [0:NUM_RK-1];
   logic [127:0]  r_rd_data;
   logic          r_ready;
   logic          r_busy;
   logic          r_done;

   logic [255:0]  w_kout;
   logic          w_expand;
   logic          w_last;
   logic [4:0]    w_idx_hi;
   logic [4:0]    w_idx_lo;
   logic [ADDR_W-1:0] w_rd_idx;
   logic [127:0]  w_rd_val;

   assign w_kout   = kexp_step(r_key, r_cnt);
   assign w_expand = (r_state == ST_EXPAND);
   assign w_last   = (r_cnt == LAST_RC);
   assign w_idx_hi = {r_cnt, 1'b0};
   assign w_idx_lo = {r_cnt, 1'b1};

   // Next-state logic; start is honoured only in IDLE or DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               w_start_acc = 1'b1;
               w_state_nxt = ST_EXPAND;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_EXPAND: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_EXPAND;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Status flags, registered from the current state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_ready <= (r_state == ST_IDLE) || (r_state == ST_DONE);
         r_busy  <= (r_state == ST_EXPAND);
         r_done  <= (r_state == ST_DONE);
      end
   end

   // Working key and round counter. The last step's output is not kept.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_key <= 256'h0;
         r_cnt <= 4'd0;
      end else if (w_start_acc) begin
         r_key <= i_key_in;
         r_cnt <= 4'd1;
      end else if (w_expand && !w_last) begin
         r_key <= w_kout;
         r_cnt <= r_cnt + 4'd1;
      end else begin
         r_key <= r_key;
         r_cnt <= r_cnt;
      end
   end

   // Round-key file. Words 0/1 come from the key itself; step cnt fills
   // 2*cnt and 2*cnt+1, except the last step, which fills only entry 14.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_RK; i++) begin
            r_rk[i] <= 128'h0;
         end
      end else begin
         for (int i = 0; i < NUM_RK; i++) begin
            if (w_start_acc && (i == 0)) begin
               r_rk[i] <= i_key_in[255:128];
            end else if (w_start_acc && (i == 1)) begin
               r_rk[i] <= i_key_in[127:0];
            end else if (w_expand && (5'(i) == w_idx_hi)) begin
               r_rk[i] <= w_kout[255:128];
            end else if (w_expand && !w_last && (5'(i) == w_idx_lo)) begin
               r_rk[i] <= w_kout[127:0];
            end else begin
               r_rk[i] <= r_rk[i];
            end
         end
      end
   end

`ifdef KEYSCHED_DEC_ORDER_EN
   // Reverse order: address 0 gives the last round key, and 15 stays out of range.
   assign w_rd_idx = (i_rd_addr == 4'hF) ? 4'hF : (4'd14 - i_rd_addr);
`else
   assign w_rd_idx = i_rd_addr;
`endif

   // Read mux. Index 15 matches no entry and returns zero.
   always_comb begin
      w_rd_val = 128'h0;
      for (int i = 0; i < NUM_RK; i++) begin
         if (ADDR_W'(i) == w_rd_idx) begin
            w_rd_val = r_rk[i];
         end else begin
            w_rd_val = w_rd_val;
         end
      end
   end

   // Registered read data, updated every cycle regardless of state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data <= 128'h0;
      end else begin
         r_rd_data <= w_rd_val;
      end
   end

   assign o_ready   = r_ready;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_rd_data = r_rd_data;

endmodule
